// File: rtl/bp_stream_host_pkg.sv
// Shared types and constants for the BlackParrot stream host console.
package bp_stream_host_pkg;

  // Command sequencing: address word, data word, action, then an optional
  // two-word response (low half first).
  typedef enum logic [2:0] {
    e_addr,
    e_data,
    e_exec,
    e_resp_lo,
    e_resp_hi
  } state_e;

  // Default MMIO addresses of the console devices.
  localparam logic [31:0] default_getchar_addr = 32'h0010_0000;
  localparam logic [31:0] default_putchar_addr = 32'h0010_1000;
  localparam logic [31:0] default_finish_addr  = 32'h0010_2000;

  // Returned by getchar when no RX byte is waiting.
  localparam logic [63:0] empty_getchar_dword = 64'hFFFF_FFFF_FFFF_FFFF;

  // Address classification result.
  typedef struct packed {
    logic is_write;
    logic is_putchar;
    logic is_finish;
    logic is_getchar;
  } decode_s;

endpackage

// File: rtl/bp_stream_host_decode.sv
// Combinational address classifier. Only putchar and finish are writes;
// every other address, mapped or not, is a read that needs a response.
module bp_stream_host_decode
  import bp_stream_host_pkg::*;
#(
  parameter logic [31:0] getchar_addr_p = default_getchar_addr,
  parameter logic [31:0] putchar_addr_p = default_putchar_addr,
  parameter logic [31:0] finish_addr_p  = default_finish_addr
) (
  input  logic [31:0] addr,
  output decode_s     dec
);

  // Full 32-bit compares; no partial decode so aliases are treated as reads.
  always_comb begin
    dec            = '0;
    dec.is_putchar = (addr == putchar_addr_p);
    dec.is_finish  = (addr == finish_addr_p);
    dec.is_getchar = (addr == getchar_addr_p);
    dec.is_write   = dec.is_putchar | dec.is_finish;
  end

endmodule

// File: rtl/bp_stream_host_console.sv
// Host-side endpoint of the BlackParrot MMIO stream: takes address/data word
// pairs, performs putchar/getchar/finish, and returns a 64-bit response as
// two stream words (low word first) for every read.
//
// Handshakes: inbound words use valid/yumi (stream_yumi_o asserts only while
// stream_v_i is high, and the word is taken on that cycle's clock edge);
// outbound words use valid/ready (stream_v_o holds with stable data until a
// cycle where stream_ready_i is high); TX uses valid/ready the same way; RX
// uses valid/yumi (rx_yumi_o pulses once, only while rx_v_i is high).
module bp_stream_host_console
  import bp_stream_host_pkg::*;
#(
  parameter int          stream_data_width_p = 32,
  parameter int          dword_width_p       = 64,
  parameter logic [31:0] getchar_addr_p      = default_getchar_addr,
  parameter logic [31:0] putchar_addr_p      = default_putchar_addr,
  parameter logic [31:0] finish_addr_p       = default_finish_addr
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           stream_v_i,
  input  logic [stream_data_width_p-1:0] stream_data_i,
  output logic                           stream_yumi_o,
  output logic                           stream_v_o,
  output logic [stream_data_width_p-1:0] stream_data_o,
  input  logic                           stream_ready_i,
  output logic                           tx_v_o,
  output logic [7:0]                     tx_data_o,
  input  logic                           tx_ready_i,
  input  logic                           rx_v_i,
  input  logic [7:0]                     rx_data_i,
  output logic                           rx_yumi_o,
  output logic                           finish_v_o,
  output logic [7:0]                     finish_code_o
);

  state_e                           state_r, state_n;
  logic [stream_data_width_p-1:0]   addr_r;
  logic [stream_data_width_p-1:0]   data_r;
  logic [dword_width_p-1:0]         resp_r;
  decode_s                          dec;

  // Only the low byte of the data word carries meaning for these devices.
  logic unused_data_bits;
  assign unused_data_bits = ^data_r[stream_data_width_p-1:8];

  bp_stream_host_decode #(
    .getchar_addr_p (getchar_addr_p),
    .putchar_addr_p (putchar_addr_p),
    .finish_addr_p  (finish_addr_p)
  ) decode (
    .addr (addr_r),
    .dec  (dec)
  );

  // State register; reset drops any partial command or pending response.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= e_addr;
    else            state_r <= state_n;
  end

  // Next-state and handshake strobes.
  always_comb begin
    state_n       = state_r;
    stream_yumi_o = 1'b0;
    tx_v_o        = 1'b0;
    rx_yumi_o     = 1'b0;
    case (state_r)
      e_addr: begin
        stream_yumi_o = stream_v_i;
        if (stream_v_i) state_n = e_data;
      end
      e_data: begin
        stream_yumi_o = stream_v_i;
        if (stream_v_i) state_n = e_exec;
      end
      e_exec: begin
        if (dec.is_putchar) begin
          tx_v_o = 1'b1;
          if (tx_ready_i) state_n = e_addr;
        end else if (dec.is_finish) begin
          state_n = e_addr;
        end else begin
          rx_yumi_o = dec.is_getchar & rx_v_i;
          state_n   = e_resp_lo;
        end
      end
      e_resp_lo: begin
        if (stream_ready_i) state_n = e_resp_hi;
      end
      e_resp_hi: begin
        if (stream_ready_i) state_n = e_addr;
      end
      default: state_n = e_addr;
    endcase
  end

  // Capture the address and data words as they are consumed.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      addr_r <= '0;
      data_r <= '0;
    end else if (stream_yumi_o) begin
      if (state_r == e_addr) addr_r <= stream_data_i;
      else                   data_r <= stream_data_i;
    end
  end

  // Build the read response once per read command in e_exec.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      resp_r <= '0;
    end else if (state_r == e_exec && !dec.is_write) begin
      if (dec.is_getchar) begin
        if (rx_v_i) resp_r <= {{(dword_width_p-8){1'b0}}, rx_data_i};
        else        resp_r <= empty_getchar_dword;
      end else begin
        resp_r <= '0;
      end
    end
  end

  // Sticky finish flag; a later finish only replaces the code.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      finish_v_o    <= 1'b0;
      finish_code_o <= 8'h00;
    end else if (state_r == e_exec && dec.is_finish) begin
      finish_v_o    <= 1'b1;
      finish_code_o <= data_r[7:0];
    end
  end

  // Response and TX outputs are decoded purely from registered state, so
  // they stay stable for as long as the consumer stalls.
  always_comb begin
    stream_v_o    = 1'b0;
    stream_data_o = '0;
    tx_data_o     = 8'h00;
    case (state_r)
      e_resp_lo: begin
        stream_v_o    = 1'b1;
        stream_data_o = resp_r[stream_data_width_p-1:0];
      end
      e_resp_hi: begin
        stream_v_o    = 1'b1;
        stream_data_o = resp_r[dword_width_p-1:stream_data_width_p];
      end
      default: ;
    endcase
    if (tx_v_o) tx_data_o = data_r[7:0];
  end

endmodule
